demux1x4_sched: RTL
===================

Name: demux1x4_sched

Overview:
Scheduler and controller for the 1-to-4 demux datapath (4-bit `a` input, 2-bit `sel` select, outputs o0..o3).
- Accepts a valid/ready stream of data words and drives the demux's `a`/`sel` inputs from registers.
- Presents a one-hot valid to the addressed consumer and holds it until that consumer is ready, or until a stall timeout expires.
- Keeps saturating per-channel transfer counts and a `sel` bit-toggle count, which the power-estimation flow reads as switching activity.

Parameters:
- DW, 4, data width driven to demux input `a`.
- CNTW, 16, width of every statistics counter.
- TO_CYC, 15, stall cycles tolerated in SEND before the word is dropped; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of all counters and `timeout_err`.
- mode  in  1  0 = directed (use `in_dest`), 1 = round-robin (use internal pointer).
- in_valid  in  1  input word valid.
- in_ready  out  1  scheduler can accept a word.
- in_data  in  DW  input word.
- in_dest  in  2  destination channel in directed mode.
- dmx_a  out  DW  registered drive to demux `a`.
- dmx_sel  out  2  registered drive to demux `sel`.
- out_valid  out  4  one-hot: channel k holds a word.
- out_ready  in  4  per-channel consumer ready.
- xfer_cnt  out  4*CNTW  per-channel completed transfers; channel k at bits [k*CNTW +: CNTW].
- drop_cnt  out  CNTW  words dropped by timeout.
- sel_tog_cnt  out  CNTW  cumulative Hamming distance of `dmx_sel` updates.
- timeout_err  out  1  sticky flag, set on any drop.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; dmx_a=0, dmx_sel=0, out_valid=0.
  - rr_ptr=0, stall counter=0.
  - All counters 0, timeout_err=0.
  - in_ready=1 once state is IDLE.
  - Reset mid-SEND abandons the word; it is not counted as a drop.
- FSM has two states, IDLE and SEND.
- in_ready is combinational: it is 1 in IDLE, or in SEND when out_ready[dmx_sel]=1 in the same cycle.
- Accept occurs when in_valid && in_ready at a clock edge. On accept:
  - dest = mode ? rr_ptr : in_dest; mode is sampled only here.
  - dmx_a <= in_data, dmx_sel <= dest.
  - out_valid <= one-hot(dest); state SEND; stall counter <= 0.
- In SEND, out_valid[dmx_sel] holds until out_ready[dmx_sel]=1 at an edge. That edge completes the transfer:
  - xfer_cnt[dmx_sel]++.
  - rr_ptr <= rr_ptr+1, wrapping 3->0, but only when the completed word was a round-robin word.
- Back-to-back: completion and a new accept on the same edge go straight to SEND with the new word. This sustains 1 word/clk with zero bubbles.
- Completion without a new accept -> IDLE, out_valid <= 0.
- In IDLE, dmx_a and dmx_sel hold their last values; they are not zeroed, to avoid needless toggling.
- Latency: accept at edge N gives out_valid visible after edge N, i.e. in cycle N+1.
- out_ready bits of non-addressed channels are ignored.
- Timeout: the stall counter increments on each SEND edge with out_ready[dmx_sel]=0. When it reaches TO_CYC:
  - The word is dropped, state -> IDLE, out_valid <= 0.
  - drop_cnt++, timeout_err <= 1.
  - rr_ptr still advances for a round-robin word.
  - in_ready stays 0 on the drop edge; no accept occurs that cycle.
- sel_tog_cnt adds popcount(old_sel ^ new_sel) on every accept, in the range 0..2.
- All counters saturate at 2^CNTW-1.
- clr has priority over a same-cycle increment: counters go to 0 and the increment is lost. clr also clears timeout_err. clr does not affect FSM state or data registers.
- out_valid is always one-hot or zero; two bits set at once is a bug.

Test Plan:
- Directed stream: mode=0, out_ready=4'b1111; words (dest,data) = (0,5),(3,7),(2,5),(3,D) on consecutive cycles -> out_valid = 0001,1000,0100,1000 on cycles 1..4, no bubbles; xfer_cnt = {2,1,0,1} for channels {3,2,1,0}; sel_tog_cnt = 2+1+1 = 4.
- Round-robin: mode=1, 6 words with in_dest=0 -> dmx_sel sequence 0,1,2,3,0,1; xfer_cnt = {1,1,2,2} for channels {3,2,1,0}; rr_ptr ends at 2.
- Backpressure: word to channel 2, out_ready[2]=0 for 3 cycles then 1 -> out_valid=0100 held 4 cycles, in_ready=0 for the 3 stalled cycles, xfer_cnt[2]=1, drop_cnt=0.
- Timeout: TO_CYC=15, word to channel 1, out_ready=0 -> out_valid[1] high for 15 cycles then low; drop_cnt=1; timeout_err=1; xfer_cnt[1]=0; next word accepted the following cycle.
- Async reset mid-SEND: assert rst_n=0 between edges while stalled -> out_valid=0, dmx_sel=0, all counters 0 immediately; after release, in_ready=1.
- Saturation and clr: CNTW=4, 17 transfers to channel 0 -> xfer_cnt[0]=15; then clr=1 together with a completing transfer -> xfer_cnt[0]=0.

Source files
------------

// File: rtl/demux1x4_sched.sv
// Scheduler for a 1-to-4 demux: accepts a valid/ready word stream, drives registered a/sel,
// presents a one-hot out_valid per channel and keeps saturating activity counters.
module demux1x4_sched #(
    parameter int DW     = 4,
    parameter int CNTW   = 16,
    parameter int TO_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic [1:0]        in_dest,
    output logic [DW-1:0]     dmx_a,
    output logic [1:0]        dmx_sel,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [4*CNTW-1:0] xfer_cnt,
    output logic [CNTW-1:0]   drop_cnt,
    output logic [CNTW-1:0]   sel_tog_cnt,
    output logic              timeout_err,
    output logic              dbg_state,
    output logic [1:0]        dbg_rr_ptr
);

    // Handshake: a word moves on a rising edge where valid && ready; ready never depends on valid.
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [7:0]      TO_LAST = 8'(TO_CYC - 1);

    state_t          state, state_nx;
    logic [DW-1:0]   a_q;
    logic [1:0]      sel_q;
    logic [3:0]      ov_q;
    logic [1:0]      rr_ptr;
    logic            rr_word;
    logic [7:0]      stall_q;
    logic [CNTW-1:0] xc_q [4];
    logic [CNTW-1:0] drop_q;
    logic [CNTW-1:0] tog_q;
    logic            err_q;

    logic            accept;
    logic            complete;
    logic            drop;
    logic            rr_adv;
    logic [1:0]      rr_eff;
    logic [1:0]      dest;
    logic [1:0]      sel_diff;
    logic [1:0]      tog_inc;
    logic [CNTW:0]   tog_sum;

    always_comb begin
        in_ready = (state == IDLE) || out_ready[sel_q];
        accept   = in_valid && in_ready;
        complete = (state == SEND) && out_ready[sel_q];
        drop     = (state == SEND) && !out_ready[sel_q] && (stall_q == TO_LAST);
        rr_adv   = (complete || drop) && rr_word;
        // A round-robin word completing on this edge must not hand its slot to the next accept.
        rr_eff   = rr_ptr + {1'b0, complete && rr_word};
        dest     = mode ? rr_eff : in_dest;
        sel_diff = sel_q ^ dest;
        tog_inc  = {1'b0, sel_diff[0]} + {1'b0, sel_diff[1]};
        tog_sum  = {1'b0, tog_q} + {{(CNTW-1){1'b0}}, tog_inc};
        state_nx = state;
        if (accept) begin
            state_nx = SEND;
        end else if (complete || drop) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            sel_q   <= '0;
            ov_q    <= '0;
            rr_ptr  <= '0;
            rr_word <= 1'b0;
            stall_q <= '0;
        end else begin
            state <= state_nx;
            if (rr_adv) begin
                rr_ptr <= rr_ptr + 2'd1;
            end
            if (accept) begin
                a_q     <= in_data;
                sel_q   <= dest;
                ov_q    <= 4'b0001 << dest;
                rr_word <= mode;
                stall_q <= '0;
            end else if (complete || drop) begin
                ov_q <= '0;
            end else if (state == SEND) begin
                stall_q <= stall_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) xc_q[k] <= '0;
            drop_q <= '0;
            tog_q  <= '0;
            err_q  <= 1'b0;
        end else if (clr) begin
            for (int k = 0; k < 4; k++) xc_q[k] <= '0;
            drop_q <= '0;
            tog_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (complete && (xc_q[sel_q] != CNT_MAX)) begin
                xc_q[sel_q] <= xc_q[sel_q] + 1'b1;
            end
            if (drop) begin
                err_q <= 1'b1;
                if (drop_q != CNT_MAX) drop_q <= drop_q + 1'b1;
            end
            if (accept) begin
                tog_q <= tog_sum[CNTW] ? CNT_MAX : tog_sum[CNTW-1:0];
            end
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_xfer
        assign xfer_cnt[k*CNTW +: CNTW] = xc_q[k];
    end

    assign dmx_a       = a_q;
    assign dmx_sel     = sel_q;
    assign out_valid   = ov_q;
    assign drop_cnt    = drop_q;
    assign sel_tog_cnt = tog_q;
    assign timeout_err = err_q;
    assign dbg_state   = state;
    assign dbg_rr_ptr  = rr_ptr;

endmodule
